// File: rtl/pc_next_sel.sv
// Next-PC selector and program-counter register for the ZAFx32 fetch stage.
// A redirect that arrives during a stall is parked in pend_q and applied on release.
module pc_next_sel #(
  parameter int WIDTH = 32,
  parameter int NSRC = 4,
  parameter int SEL_W = 2,
  parameter int STEP = 4,
  parameter int ALIGN = 2,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        stall,
  input  logic [SEL_W-1:0]            sel,
  input  logic [(NSRC-1)*WIDTH-1:0]   targets,
  output logic [WIDTH-1:0]            pc,
  output logic [WIDTH-1:0]            pc_plus,
  output logic                        pending,
  output logic                        redirect,
  output logic                        sel_err,
  output logic                        align_err
);

  typedef enum logic {RUN, HOLD} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic             redirect_q, redirect_d;
  logic             sel_err_q, sel_err_d;
  logic             align_err_q, align_err_d;
  logic [WIDTH-1:0] tgt;
  logic             req;
  logic             misal;

  assign pc_plus = pc_q + WIDTH'(STEP);
  assign req = (sel != '0);
  assign sel_err_d = (int'(sel) >= NSRC);

  // Out-of-range selects fall back to a zero target for legacy compatibility.
  always_comb begin
    tgt = '0;
    if (sel == '0) begin
      tgt = pc_plus;
    end else begin
      for (int k = 1; k < NSRC; k++) begin
        if (sel == SEL_W'(k)) tgt = targets[(k-1)*WIDTH +: WIDTH];
      end
    end
  end

  generate
    if (ALIGN > 0) begin : g_align
      assign misal = req && (tgt[ALIGN-1:0] != '0);
    end else begin : g_noalign
      assign misal = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      pc_q        <= RESET_PC;
      pend_q      <= '0;
      redirect_q  <= 1'b0;
      sel_err_q   <= 1'b0;
      align_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      pend_q      <= pend_d;
      redirect_q  <= redirect_d;
      sel_err_q   <= sel_err_d;
      align_err_q <= align_err_d;
    end
  end

  // On stall release from HOLD the parked target wins; the live request is ignored.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    pend_d      = pend_q;
    redirect_d  = 1'b0;
    align_err_d = 1'b0;
    unique case (state_q)
      RUN: begin
        if (misal) begin
          align_err_d = 1'b1;
        end else if (!stall) begin
          pc_d       = tgt;
          redirect_d = req;
        end else if (req) begin
          pend_d  = tgt;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (!stall) begin
          pc_d       = pend_q;
          redirect_d = 1'b1;
          state_d    = RUN;
        end else if (misal) begin
          align_err_d = 1'b1;
        end else if (req) begin
          pend_d = tgt;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    pc        = pc_q;
    pending   = (state_q == HOLD);
    redirect  = redirect_q;
    sel_err   = sel_err_q;
    align_err = align_err_q;
  end

endmodule
